mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register outputs. Drives a req/ack data-memory port
//  (byte/half/word, sign/zero-extended loads) and raises stall_mem_o while an access is in flight.
//  Owns the MEM/WB pipeline register feeding writeback; flags misaligned/illegal/timed-out accesses.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles in WAIT without dmem_ack_i before bus error (>=2)
// PORTS
//  clk_i          in   1   clock, rising edge
//  reset_ni       in   1   reset, asynchronous, active-low
//  aluresultm_i   in   32  address / ALU result from EX/MEM
//  writedatam_i   in   32  store data from EX/MEM
//  rdm_i          in   5   destination register
//  pcplus4m_i     in   32  PC+4
//  funct3m_i      in   3   access size/sign (000 B,001 H,010 W,100 BU,101 HU)
//  memreadm_i     in   1   load
//  memwritem_i    in   1   store (memreadm_i&memwritem_i = illegal)
//  regwritem_i    in   1   instruction writes rd
//  resultsrcm_i   in   2   WB result select, passed through
//  dmem_req_o     out  1   memory request
//  dmem_we_o      out  1   1 = write
//  dmem_addr_o    out  32  word address {aluresultm_i[31:2],2'b00}
//  dmem_be_o      out  4   byte enables
//  dmem_wdata_o   out  32  lane-aligned store data
//  dmem_ack_i     in   1   access complete; dmem_rdata_i valid this cycle
//  dmem_rdata_i   in   32  read word
//  stall_mem_o    out  1   hold IF..EX/MEM this cycle
//  readdataw_o / aluresultw_o / pcplus4w_o  out 32  MEM/WB data
//  rdw_o out 5; regwritew_o out 1; resultsrcw_o out 2   MEM/WB control
//  memexcw_o      out  1   MEM/WB: access faulted (misalign/illegal/timeout)
// BEHAVIOUR
//  - Reset (reset_ni=0, async): state IDLE, timeout counter 0, all MEM/WB outputs 0; dmem_req_o,
//    stall_mem_o 0 while in reset. Reset mid-access abandons the request; no retry after release.
//  - op = memreadm_i|memwritem_i. fault = misaligned (H: addr[0]; W: addr[1:0]!=0), funct3 not
//    in table, or read&write both set. Faulting ops never assert dmem_req_o.
//  - FSM IDLE: op&!fault -> dmem_req_o=1 combinationally, same cycle. ack same cycle -> complete,
//    stay IDLE (0-wait memory); else -> WAIT, counter=1.
//  - WAIT: dmem_req_o held 1; addr/we/be/wdata held stable (EX/MEM frozen by stall). ack -> complete,
//    IDLE. Counter reaches TIMEOUT_CYCLES w/o ack -> timeout: IDLE, req drops, op retires faulted.
//  - stall_mem_o = (IDLE&op&!fault&!ack) | (WAIT&!ack&!timeout). Never asserted on the ack edge.
//  - Stores: SB be=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}; SH be=addr[1]?1100:0011,
//    wdata={2{wd[15:0]}}; SW be=1111, wdata=wd.
//  - Loads: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W raw.
//  - MEM/WB capture each edge: stall_mem_o=1 -> bubble (regwritew_o=0, memexcw_o=0, others hold).
//    Else capture inputs; readdataw_o = extended load data (0 for non-loads); faulted op ->
//    regwritew_o=0, memexcw_o=1 for one cycle. Latency: load data visible 1 edge after ack.
//  - Non-memory ops pass through with 1-cycle latency, no stall.
// STRUCTURE
//  - riscv_pkg: funct3 constants (F3_B/H/W/BU/HU), lsu_state_t enum {IDLE,WAIT}.
//  - Sub-module lsu_align (combinational): be/wdata generation, load extraction/extension, fault.
// TESTING
//  1 SW addr 0x100 data 0xDEADBEEF, ack same cycle -> req=1,we=1,be=1111, no stall, WB bubble-free.
//  2 LB addr 0x103, rdata 0x80FF_0000, ack after 3 cycles -> stall 3 cycles, readdataw=0xFFFFFF80.
//  3 LHU addr 0x102, rdata 0x8001_1234 -> readdataw=0x00008001; LH same -> 0xFFFF8001.
//  4 LW addr 0x102 -> no req, no stall, memexcw_o=1, regwritew_o=0 next cycle.
//  5 load, ack never -> stall exactly TIMEOUT_CYCLES cycles, then req=0, memexcw_o=1.
//  6 reset_ni low in WAIT -> req/stall/WB outputs 0 immediately (async); after release, IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the MEM stage: load/store size codes and LSU FSM states.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, and
// size/alignment fault detection. Purely combinational.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata_ext,
    output logic        o_size_fault
);

    logic [31:0] w_rshift;

    assign w_rshift = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = i_wdata;
        o_rdata_ext  = 32'h0000_0000;
        o_size_fault = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_wdata[7:0]}};
                o_rdata_ext = {{24{w_rshift[7] & (i_funct3 == F3_B)}}, w_rshift[7:0]};
            end
            F3_H, F3_HU: begin
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata_ext  = {{16{w_rshift[15] & (i_funct3 == F3_H)}}, w_rshift[15:0]};
                o_size_fault = i_addr_lo[0];
            end
            F3_W: begin
                o_be         = 4'b1111;
                o_rdata_ext  = i_rdata;
                o_size_fault = (i_addr_lo != 2'b00);
            end
            default: o_size_fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: req/ack data-memory port, pipeline stall while an access is
// outstanding, and the MEM/WB register. States: IDLE | no access pending
// (0-wait completion possible), WAIT | request issued, awaiting ack or timeout.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] aluresultm_i,
    input  logic [31:0] writedatam_i,
    input  logic [4:0]  rdm_i,
    input  logic [31:0] pcplus4m_i,
    input  logic [2:0]  funct3m_i,
    input  logic        memreadm_i,
    input  logic        memwritem_i,
    input  logic        regwritem_i,
    input  logic [1:0]  resultsrcm_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_mem_o,
    output logic [31:0] readdataw_o,
    output logic [31:0] aluresultw_o,
    output logic [31:0] pcplus4w_o,
    output logic [4:0]  rdw_o,
    output logic        regwritew_o,
    output logic [1:0]  resultsrcw_o,
    output logic        memexcw_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_op, w_fault, w_size_fault, w_exc;
    logic          w_req, w_stall, w_timeout;
    logic [31:0]   w_rdata_ext;

    logic [31:0]   r_readdataw, r_aluresultw, r_pcplus4w;
    logic [4:0]    r_rdw;
    logic          r_regwritew, r_memexcw;
    logic [1:0]    r_resultsrcw;

    lsu_align u_align (
        .i_addr_lo    (aluresultm_i[1:0]),
        .i_funct3     (funct3m_i),
        .i_wdata      (writedatam_i),
        .i_rdata      (dmem_rdata_i),
        .o_be         (dmem_be_o),
        .o_wdata      (dmem_wdata_o),
        .o_rdata_ext  (w_rdata_ext),
        .o_size_fault (w_size_fault)
    );

    assign w_op    = memreadm_i | memwritem_i;
    assign w_fault = w_op & (w_size_fault | (memreadm_i & memwritem_i));
    assign w_exc   = w_fault | w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_op && !w_fault) begin
                    w_req = 1'b1;
                    if (!dmem_ack_i) begin
                        w_stall     = 1'b1;
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CW'(1);
                    end
                end
            end
            WAIT: begin
                w_req = 1'b1;
                if (dmem_ack_i) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CW'(TIMEOUT_CYCLES)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are combinational from EX/MEM, so mask them while reset is held.
    assign dmem_req_o  = reset_ni & w_req;
    assign stall_mem_o = reset_ni & w_stall;
    assign dmem_we_o   = memwritem_i;
    assign dmem_addr_o = {aluresultm_i[31:2], 2'b00};

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_readdataw  <= '0;
            r_aluresultw <= '0;
            r_pcplus4w   <= '0;
            r_rdw        <= '0;
            r_regwritew  <= 1'b0;
            r_memexcw    <= 1'b0;
            r_resultsrcw <= '0;
        end else if (w_stall) begin
            r_regwritew <= 1'b0;
            r_memexcw   <= 1'b0;
        end else begin
            r_readdataw  <= (memreadm_i && dmem_ack_i && !w_fault) ? w_rdata_ext : '0;
            r_aluresultw <= aluresultm_i;
            r_pcplus4w   <= pcplus4m_i;
            r_rdw        <= rdm_i;
            r_regwritew  <= regwritem_i & ~w_exc;
            r_memexcw    <= w_exc;
            r_resultsrcw <= resultsrcm_i;
        end
    end

    assign readdataw_o  = r_readdataw;
    assign aluresultw_o = r_aluresultw;
    assign pcplus4w_o   = r_pcplus4w;
    assign rdw_o        = r_rdw;
    assign regwritew_o  = r_regwritew;
    assign memexcw_o    = r_memexcw;
    assign resultsrcw_o = r_resultsrcw;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a transaction-level model sets per-cycle
// expectations, a single negedge process compares, and literals pin key results.
module tb_mem_stage_lsu;
    import riscv_pkg::*;

    localparam int T = 16;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [31:0] aluresultm_i, writedatam_i, pcplus4m_i, dmem_rdata_i;
    logic [4:0]  rdm_i;
    logic [2:0]  funct3m_i;
    logic        memreadm_i, memwritem_i, regwritem_i, dmem_ack_i;
    logic [1:0]  resultsrcm_i;
    logic        dmem_req_o, dmem_we_o, stall_mem_o, regwritew_o, memexcw_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, readdataw_o, aluresultw_o, pcplus4w_o;
    logic [3:0]  dmem_be_o;
    logic [4:0]  rdw_o;
    logic [1:0]  resultsrcw_o;

    mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .aluresultm_i(aluresultm_i), .writedatam_i(writedatam_i), .rdm_i(rdm_i),
        .pcplus4m_i(pcplus4m_i), .funct3m_i(funct3m_i), .memreadm_i(memreadm_i),
        .memwritem_i(memwritem_i), .regwritem_i(regwritem_i), .resultsrcm_i(resultsrcm_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .stall_mem_o(stall_mem_o),
        .readdataw_o(readdataw_o), .aluresultw_o(aluresultw_o), .pcplus4w_o(pcplus4w_o),
        .rdw_o(rdw_o), .regwritew_o(regwritew_o), .resultsrcw_o(resultsrcw_o),
        .memexcw_o(memexcw_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    int stall_cnt = 0;
    bit chk_en = 0;

    logic        exp_req, exp_stall, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] e_rdata, e_alu, e_pc;
    logic [4:0]  e_rd;
    logic        e_rw, e_exc;
    logic [1:0]  e_rs;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
        logic [31:0] s;
        s = w >> (8 * int'(a));
        case (f3)
            3'b000:  return s[7]  ? ((s & 32'hFF)   | 32'hFFFF_FF00) : (s & 32'hFF);
            3'b100:  return s & 32'hFF;
            3'b001:  return s[15] ? ((s & 32'hFFFF) | 32'hFFFF_0000) : (s & 32'hFFFF);
            3'b101:  return s & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic bit m_fault(input logic [1:0] a, input logic [2:0] f3, input bit rd, input bit wr);
        if (!(rd || wr)) return 1'b0;
        if (rd && wr) return 1'b1;
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return (int'(a) % 2) != 0;
            3'b010:         return a != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] a, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 4'(1 << int'(a));
            3'b001, 3'b101: return (a >= 2) ? 4'hC : 4'h3;
            default:        return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return (wd & 32'hFF) * 32'h0101_0101;
            3'b001, 3'b101: return (wd & 32'hFFFF) * 32'h0001_0001;
            default:        return wd;
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (chk_en) begin
            check32("req", dmem_req_o, exp_req);
            check32("stall", stall_mem_o, exp_stall);
            if (exp_req) begin
                check32("addr", dmem_addr_o, exp_addr);
                check32("we", dmem_we_o, exp_we);
                if (exp_we) begin
                    check32("be", dmem_be_o, exp_be);
                    check32("wdata", dmem_wdata_o, exp_wdata);
                end
            end
            check32("readdataw", readdataw_o, e_rdata);
            check32("aluresultw", aluresultw_o, e_alu);
            check32("pcplus4w", pcplus4w_o, e_pc);
            check32("rdw", rdw_o, e_rd);
            check32("regwritew", regwritew_o, e_rw);
            check32("memexcw", memexcw_o, e_exc);
            check32("resultsrcw", resultsrcw_o, e_rs);
            if (stall_mem_o) stall_cnt++;
        end
    end

    // delay: cycles until ack (0 = same cycle); negative = never acknowledged.
    task automatic do_op(input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                         input logic [2:0] f3, input bit rd, input bit wr, input bit rw,
                         input logic [4:0] rdn, input int delay);
        bit f, op, acked;
        int n_wait;
        f  = m_fault(addr[1:0], f3, rd, wr);
        op = rd || wr;
        if (!op || f) begin
            n_wait = 0; acked = 0;
        end else if (delay >= 0 && delay < T) begin
            n_wait = delay; acked = 1;
        end else begin
            n_wait = T; acked = 0;
        end
        aluresultm_i = addr; writedatam_i = wd; dmem_rdata_i = rdata;
        funct3m_i = f3; memreadm_i = rd; memwritem_i = wr; regwritem_i = rw;
        rdm_i = rdn; pcplus4m_i = 32'h0000_1000 + addr; resultsrcm_i = rdn[1:0];
        exp_addr = {addr[31:2], 2'b00}; exp_we = wr;
        exp_be = m_be(addr[1:0], f3); exp_wdata = m_wdata(wd, f3);
        for (int i = 0; i <= n_wait; i++) begin
            if (i > 0) begin e_rw = 0; e_exc = 0; end
            exp_req    = op && !f;
            exp_stall  = (i < n_wait);
            dmem_ack_i = acked && (i == n_wait);
            @(posedge clk_i); #1;
        end
        dmem_ack_i = 0;
        e_alu = addr; e_pc = 32'h0000_1000 + addr; e_rd = rdn; e_rs = rdn[1:0];
        e_exc   = f || (op && !acked);
        e_rw    = rw && !e_exc;
        e_rdata = (rd && !e_exc) ? m_load(rdata, addr[1:0], f3) : 32'h0;
    endtask

    task automatic nop();
        do_op(32'h0000_0040, 32'h0, 32'h0, F3_W, 0, 0, 1, 5'd1, 0);
    endtask

    initial begin
        int s0;
        reset_ni = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
        aluresultm_i = 0; writedatam_i = 0; rdm_i = 0; pcplus4m_i = 0;
        funct3m_i = 0; memreadm_i = 0; memwritem_i = 0; regwritem_i = 0; resultsrcm_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        check32("rst_req", dmem_req_o, 0);
        check32("rst_stall", stall_mem_o, 0);
        check32("rst_regwritew", regwritew_o, 0);
        check32("rst_readdataw", readdataw_o, 0);
        check32("rst_memexcw", memexcw_o, 0);
        reset_ni = 1;
        e_rdata = 0; e_alu = 0; e_pc = 0; e_rd = 0; e_rw = 0; e_exc = 0; e_rs = 0;
        chk_en = 1;

        s0 = stall_cnt;
        do_op(32'h0000_0100, 32'hDEAD_BEEF, 32'h0, F3_W, 0, 1, 0, 5'd0, 0);
        check32("t1_stalls", stall_cnt - s0, 0);
        check32("t1_exc", memexcw_o, 0);

        s0 = stall_cnt;
        do_op(32'h0000_0103, 32'h0, 32'h80FF_0000, F3_B, 1, 0, 1, 5'd5, 3);
        check32("t2_stalls", stall_cnt - s0, 3);
        check32("t2_lb", readdataw_o, 32'hFFFF_FF80);
        check32("t2_rw", regwritew_o, 1);

        do_op(32'h0000_0102, 32'h0, 32'h8001_1234, F3_HU, 1, 0, 1, 5'd6, 1);
        check32("t3_lhu", readdataw_o, 32'h0000_8001);
        do_op(32'h0000_0102, 32'h0, 32'h8001_1234, F3_H, 1, 0, 1, 5'd6, 0);
        check32("t3_lh", readdataw_o, 32'hFFFF_8001);

        s0 = stall_cnt;
        do_op(32'h0000_0102, 32'h0, 32'h1234_5678, F3_W, 1, 0, 1, 5'd7, 0);
        check32("t4_exc", memexcw_o, 1);
        check32("t4_rw", regwritew_o, 0);
        check32("t4_stalls", stall_cnt - s0, 0);
        nop();
        check32("t4_exc_clear", memexcw_o, 0);

        do_op(32'h0000_0101, 32'h1234_5678, 32'h0, F3_B, 0, 1, 0, 5'd0, 2);
        do_op(32'h0000_0102, 32'h1234_5678, 32'h0, F3_H, 0, 1, 0, 5'd0, 0);
        do_op(32'h0000_0101, 32'h0, 32'h1122_3344, F3_BU, 1, 0, 1, 5'd9, 0);
        check32("lbu", readdataw_o, 32'h0000_0033);
        do_op(32'h0000_0104, 32'h0, 32'hCAFE_F00D, F3_W, 1, 0, 1, 5'd10, 15);
        check32("lw_late_ack", readdataw_o, 32'hCAFE_F00D);
        do_op(32'h0000_0101, 32'h0, 32'h0, F3_H, 0, 1, 0, 5'd0, 0);
        do_op(32'h0000_0100, 32'h0, 32'h0, 3'b011, 1, 0, 1, 5'd11, 0);
        do_op(32'h0000_0100, 32'h0, 32'h0, F3_W, 1, 1, 1, 5'd12, 0);
        do_op(32'h0000_1234, 32'h0, 32'h0, 3'b111, 0, 0, 1, 5'd13, 0);
        check32("alu_pass", aluresultw_o, 32'h0000_1234);

        s0 = stall_cnt;
        do_op(32'h0000_0108, 32'h0, 32'h5555_AAAA, F3_W, 1, 0, 1, 5'd14, -1);
        check32("t5_stalls", stall_cnt - s0, T);
        check32("t5_exc", memexcw_o, 1);
        check32("t5_readdata", readdataw_o, 0);
        nop();

        chk_en = 0;
        aluresultm_i = 32'h0000_0200; funct3m_i = F3_W; memreadm_i = 1; memwritem_i = 0;
        regwritem_i = 1; rdm_i = 5'd7; dmem_ack_i = 0;
        repeat (4) @(posedge clk_i);
        #2;
        check32("t6_req_before", dmem_req_o, 1);
        reset_ni = 0;
        #1;
        check32("t6_req", dmem_req_o, 0);
        check32("t6_stall", stall_mem_o, 0);
        check32("t6_aluresultw", aluresultw_o, 0);
        check32("t6_pcplus4w", pcplus4w_o, 0);
        check32("t6_rdw", rdw_o, 0);
        check32("t6_regwritew", regwritew_o, 0);
        check32("t6_resultsrcw", resultsrcw_o, 0);
        memreadm_i = 0; regwritem_i = 0;
        @(posedge clk_i); #1;
        reset_ni = 1;
        e_rdata = 0; e_alu = 0; e_pc = 0; e_rd = 0; e_rw = 0; e_exc = 0; e_rs = 0;
        chk_en = 1;
        nop();
        s0 = stall_cnt;
        do_op(32'h0000_0200, 32'h0, 32'h0BAD_F00D, F3_W, 1, 0, 1, 5'd7, 0);
        check32("t6_post_stalls", stall_cnt - s0, 0);
        check32("t6_post_load", readdataw_o, 32'h0BAD_F00D);
        nop();
        chk_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
